// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The master side feeds program bytes and receives memory writes; the
// loader itself sits on the slave side.
interface instr_mem_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_last;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output byte_in,
        output byte_valid,
        output byte_last,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        input  byte_last,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: packs a big-endian byte stream into 32-bit
// words and writes them to consecutive word addresses starting at 0.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | after reset, waiting for start
//   COLLECT | accepting bytes of the current word
//   WRITE   | one-cycle write strobe of the assembled word
//   DONE    | final word written, waiting for a new start
//   ERROR   | partial final word or memory overflow, waiting for start
module instr_mem_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    instr_mem_loader_if.slave   bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [31:0]         word_count
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE,
        ERROR
    } state_t;

    localparam logic [31:0] LAST_ADDR = 32'(MAX_WORDS - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] shift_word;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [31:0] count;
    logic [1:0]  byte_idx;
    logic        last_flag;
    logic        start_ok;
    logic        accept;

    // start is honoured only when no session is running
    assign start_ok = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign accept   = bus.byte_valid && (state == COLLECT);

    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign word_count    = count;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        state_next     = state;
        bus.byte_ready = 1'b0;
        bus.mem_we     = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_next = COLLECT;
            end
            COLLECT: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (accept) begin
                    if (byte_idx == 2'd3) begin
                        state_next = WRITE;
                    end else if (bus.byte_last) begin
                        state_next = ERROR;
                    end
                end
            end
            WRITE: begin
                bus.mem_we = 1'b1;
                busy       = 1'b1;
                if (last_flag) begin
                    state_next = DONE;
                end else if (addr == LAST_ADDR) begin
                    state_next = ERROR;
                end else begin
                    state_next = COLLECT;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start_ok) state_next = COLLECT;
            end
            ERROR: begin
                error = 1'b1;
                if (start_ok) state_next = COLLECT;
            end
            default: state_next = IDLE;
        endcase
    end

    // Word assembly, address/count tracking; wdata is captured with the
    // 4th byte so it stays stable while the next word shifts in
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_word <= '0;
            wdata      <= '0;
            addr       <= '0;
            count      <= '0;
            byte_idx   <= '0;
            last_flag  <= 1'b0;
        end else if (start_ok) begin
            addr      <= '0;
            count     <= '0;
            byte_idx  <= '0;
            last_flag <= 1'b0;
        end else if (accept) begin
            shift_word <= {shift_word[23:0], bus.byte_in};
            byte_idx   <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
                wdata     <= {shift_word[23:0], bus.byte_in};
                last_flag <= bus.byte_last;
            end
        end else if (state == WRITE) begin
            addr  <= addr + 32'd1;
            count <= count + 32'd1;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised and directed bench for instr_mem_loader with a transaction-level
// reference model: expected writes are derived from the byte program itself.
module tb_instr_mem_loader;

    localparam int MAX_WORDS = 4;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] word_count;

    instr_mem_loader_if bus ();

    instr_mem_loader #(.MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    wr_t         exp_q[$];
    int          wr_cycles[$];
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;
    logic [7:0]  prog [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare every write strobe against the model's expected write queue
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL write_missing: no write seen, expected addr %0d at cycle %0d", exp_q[0].addr, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (bus.mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", bus.mem_addr, bus.mem_wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", bus.mem_addr, 32'(e.addr));
                    check("write_data", bus.mem_wdata, e.data);
                    check("write_cycle", 32'(cyc), 32'(e.cyc));
                end
                check("ready_in_write", {31'd0, bus.byte_ready}, 32'd0);
                check("busy_in_write", {31'd0, busy}, 32'd1);
                wr_cycles.push_back(cyc);
                last_waddr = bus.mem_addr;
                last_wdata = bus.mem_wdata;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    {31'd0, bus.mem_we}, 32'd0);
        check({tag, "_addr"},  bus.mem_addr, 32'd0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_count"}, word_count, 32'd0);
        check({tag, "_ready"}, {31'd0, bus.byte_ready}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_done"},  {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    // Runs one load session from the current negedge. last_at is the
    // 1-based position of the byte flagged last (0 = none).
    task automatic run_session(input int nbytes, input int last_at, input bit gaps,
                               input bit rstart, output bit ended, output bit ok_done,
                               output int nw);
        int          i;
        int          w;
        int          budget;
        int          wr_cyc;
        int          pos;
        bit          v;
        bit          exp_rdy;
        logic [31:0] wd;
        i = 0; w = 0; budget = 0; wr_cyc = -10;
        ended = 1'b0; ok_done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy",  {31'd0, busy}, 32'd1);
        check("start_done",  {31'd0, done}, 32'd0);
        check("start_error", {31'd0, error}, 32'd0);
        check("start_count", word_count, 32'd0);
        while (i < nbytes && !ended && budget < 500) begin
            budget++;
            v              = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.byte_valid = v;
            bus.byte_in    = prog[i];
            bus.byte_last  = (last_at == i + 1);
            start          = rstart ? ($urandom_range(0, 4) == 0) : 1'b0;
            exp_rdy        = (cyc != wr_cyc);
            check("byte_ready", {31'd0, bus.byte_ready}, {31'd0, exp_rdy});
            if (v && exp_rdy) begin
                i++;
                pos = i;
                if (pos % 4 == 0) begin
                    wd = (32'(prog[pos-4]) << 24) | (32'(prog[pos-3]) << 16) |
                         (32'(prog[pos-2]) << 8)  |  32'(prog[pos-1]);
                    exp_q.push_back('{w, wd, cyc + 1});
                    wr_cyc = cyc + 1;
                    w++;
                    if (last_at == pos) begin
                        ended = 1'b1; ok_done = 1'b1;
                    end else if (w == MAX_WORDS) begin
                        ended = 1'b1;
                    end
                end else if (last_at == pos) begin
                    ended = 1'b1;
                end
            end
            @(negedge clk);
        end
        if (budget >= 500) begin
            n_vec++;
            n_err++;
            $display("FAIL session_timeout: %0d of %0d bytes accepted", i, nbytes);
        end
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        start          = 1'b0;
        repeat (3) @(negedge clk);
        check("end_busy",  {31'd0, busy},  {31'd0, !ended});
        check("end_done",  {31'd0, done},  {31'd0, ended && ok_done});
        check("end_error", {31'd0, error}, {31'd0, ended && !ok_done});
        check("end_count", word_count, 32'(w));
        check("end_pending", 32'(exp_q.size()), 32'd0);
        nw = w;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ended;
        bit ok;
        int nw;
        int nb;
        int la;

        rst_n = 1'b0; start = 1'b0;
        bus.byte_valid = 1'b0; bus.byte_last = 1'b0; bus.byte_in = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // single word program
        prog[0] = 8'h20; prog[1] = 8'h08; prog[2] = 8'h00; prog[3] = 8'h05;
        run_session(4, 4, 1'b0, 1'b0, ended, ok, nw);
        check("w1_data", last_wdata, 32'h2008_0005);
        check("w1_addr", last_waddr, 32'd0);
        check("w1_count", word_count, 32'd1);
        check("w1_done", {31'd0, done}, 32'd1);

        // three words back-to-back; restart from DONE
        for (int k = 0; k < 12; k++) prog[k] = 8'($urandom);
        wr_cycles.delete();
        run_session(12, 12, 1'b0, 1'b0, ended, ok, nw);
        check("w3_nwrites", 32'(wr_cycles.size()), 32'd3);
        if (wr_cycles.size() == 3) begin
            check("w3_gap01", 32'(wr_cycles[1] - wr_cycles[0]), 32'd5);
            check("w3_gap12", 32'(wr_cycles[2] - wr_cycles[1]), 32'd5);
        end
        check("w3_count", word_count, 32'd3);
        check("w3_done", {31'd0, done}, 32'd1);
        check("w3_last_addr", last_waddr, 32'd2);

        // start pulses during the session are ignored
        for (int k = 0; k < 8; k++) prog[k] = 8'($urandom);
        run_session(8, 8, 1'b0, 1'b1, ended, ok, nw);
        check("ign_count", word_count, 32'd2);
        check("ign_last_addr", last_waddr, 32'd1);

        // partial final word
        run_session(8, 6, 1'b0, 1'b0, ended, ok, nw);
        check("part_count", word_count, 32'd1);
        check("part_error", {31'd0, error}, 32'd1);
        check("part_busy", {31'd0, busy}, 32'd0);

        // overflow: 20 bytes, no last
        for (int k = 0; k < 20; k++) prog[k] = 8'($urandom);
        run_session(20, 0, 1'b0, 1'b0, ended, ok, nw);
        check("ovf_count", word_count, 32'd4);
        check("ovf_error", {31'd0, error}, 32'd1);
        check("ovf_last_addr", last_waddr, 32'd3);
        bus.byte_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("ovf_ready", {31'd0, bus.byte_ready}, 32'd0);
        end
        bus.byte_valid = 1'b0;

        // reset after two bytes, then a fresh single-word session
        run_session(2, 0, 1'b0, 1'b0, ended, ok, nw);
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        check_all_zero("midrst");
        rst_n = 1'b1;
        prog[0] = 8'hde; prog[1] = 8'had; prog[2] = 8'hbe; prog[3] = 8'hef;
        run_session(4, 4, 1'b0, 1'b0, ended, ok, nw);
        check("rst_addr", last_waddr, 32'd0);
        check("rst_data", last_wdata, 32'hdead_beef);

        // randomised sessions
        for (int s = 0; s < 30; s++) begin
            nb = $urandom_range(1, 24);
            la = $urandom_range(1, nb);
            for (int k = 0; k < nb; k++) prog[k] = 8'($urandom);
            run_session(nb, la, 1'b1, 1'($urandom_range(0, 1)), ended, ok, nw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter: MAX_WORDS, default 256; instruction memory capacity in 32-bit words.
REQ-002 Port: clk  input  1  single clock, all logic rising-edge triggered.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset.
REQ-004 Port: start  input  1  begin load session; sampled only in IDLE, DONE, ERROR.
REQ-005 Port: byte_in  input  8  program byte stream, most-significant byte of each instruction first.
REQ-006 Port: byte_valid  input  1  byte_in holds a valid byte.
REQ-007 Port: byte_last  input  1  qualifies the final byte of the program; meaningful only with byte_valid.
REQ-008 Port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 Port: mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-010 Port: mem_addr  output  32  word address of the write (0, 1, 2, ...).
REQ-011 Port: mem_wdata  output  32  assembled instruction word.
REQ-012 Port: busy  output  1  session in progress (COLLECT or WRITE).
REQ-013 Port: done  output  1  program fully written; held until next start or reset.
REQ-014 Port: error  output  1  session aborted; held until next start or reset.
REQ-015 Port: word_count  output  32  words written in the current/last session.

Function
REQ-016 FSM states SHALL be IDLE, COLLECT, WRITE, DONE, ERROR.
REQ-017 IDLE/DONE/ERROR: start=1 -> COLLECT next cycle; mem_addr, word_count, byte index cleared; done, error cleared.
REQ-018 byte_ready SHALL be 1 only in COLLECT; a byte is accepted on byte_valid && byte_ready.
REQ-019 Accepted bytes SHALL shift in big-endian: word <= {word[23:0], byte_in}; byte index increments mod 4.
REQ-020 Acceptance of the 4th byte (index 3) SHALL move to WRITE, latching byte_last into a last flag.
REQ-021 WRITE SHALL last exactly one cycle with mem_we=1, mem_addr=current address, mem_wdata=assembled word; latency 1 cycle from 4th-byte acceptance.
REQ-022 Leaving WRITE: mem_addr and word_count SHALL increment by 1; last flag set -> DONE; else mem_addr was MAX_WORDS-1 -> ERROR (overflow); else -> COLLECT.
REQ-023 byte_last accepted with byte index 0-2 (partial word) SHALL go to ERROR with no write of the partial word.
REQ-024 Outside WRITE, mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.
REQ-025 start while busy SHALL be ignored.
REQ-026 Sustained throughput SHALL be 4 bytes per 5 cycles with byte_valid held high.
REQ-027 busy=1 in COLLECT and WRITE; done=1 only in DONE; error=1 only in ERROR.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force IDLE and zero mem_we, mem_addr, mem_wdata, word_count, byte_ready, busy, done, error, byte index, last flag.
REQ-029 Reset mid-session SHALL abandon the partial word with no further write; resumption only via new start.

Verification
REQ-030 Bytes 0x20,0x08,0x00,0x05 (last on 4th) after start -> one mem_we pulse, addr 0, data 0x20080005; done=1, word_count=1.
REQ-031 12 bytes back-to-back, last on 12th -> writes at addr 0,1,2 each 5 cycles apart, byte_ready low during each WRITE cycle; done, word_count=3.
REQ-032 byte_last on 2nd byte of second word -> exactly one write (addr 0), then error=1, busy=0, word_count=1.
REQ-033 MAX_WORDS=4, 20 bytes without last -> writes at addr 0..3, ERROR after 4th write, no 5th write.
REQ-034 rst_n low after 2 bytes accepted -> all outputs zero next cycle, no write; new start then 4 bytes -> write at addr 0.
REQ-035 start pulsed during COLLECT -> ignored, address sequence unaffected; start in DONE -> done cleared, word_count=0, new session from addr 0.
